ping_scheduler: RTL and testbench

//  Round-robin scheduler sharing one ping (ultrasonic echo-timing) engine among up to
//  N_SENSORS HC-SR04-style sensors. Selects a sensor, drives the engine's req/done handshake,

---
 rtl/ping_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_ping_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ping_scheduler.sv
// Round-robin scheduler sharing one ultrasonic ping engine among several sensors.
// Optional nearest-reading tracker enabled by defining PING_SCHED_NEAREST_EN.
module ping_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int ID_W           = 2,
  parameter int CM_W           = 9,
  parameter int GAP_CYCLES     = 1500000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] mask,
  output logic                 req,
  output logic [ID_W-1:0]      sel,
  input  logic                 done,
  input  logic [CM_W-1:0]      cm,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  output logic [CM_W-1:0]      res_cm,
  output logic                 res_timeout,
  input  logic [ID_W-1:0]      rd_id,
  output logic [CM_W-1:0]      rd_cm,
  output logic                 busy
`ifdef PING_SCHED_NEAREST_EN
  ,
  output logic [CM_W-1:0]      near_cm,
  output logic [ID_W-1:0]      near_id
`endif
);

  localparam int MAX_CYC = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, PICK, PING, GAP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       sel_q, sel_d;
  logic                  res_valid_q, res_valid_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;
  logic [CM_W-1:0]       res_cm_q, res_cm_d;
  logic                  res_timeout_q, res_timeout_d;
  logic [CM_W-1:0]       tbl_q [N_SENSORS];
  logic [CM_W-1:0]       tbl_d [N_SENSORS];

  logic [ID_W-1:0]       next_id;
  logic [ID_W-1:0]       cand;
  logic                  next_found;
  logic                  ping_done;
  logic                  ping_timeout;
  logic                  ping_exit;
  logic                  gap_end;

  // First set mask bit strictly after the last pinged sensor, wrapping; the pointer itself comes last.
  always_comb begin
    next_id    = ptr_q;
    next_found = 1'b0;
    cand       = '0;
    for (int i = 1; i <= N_SENSORS; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % N_SENSORS);
      if (!next_found && mask[cand]) begin
        next_found = 1'b1;
        next_id    = cand;
      end
    end
  end

  assign ping_done    = (state_q == PING) && done;
  assign ping_timeout = (state_q == PING) && !done && (timer_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ping_exit    = ping_done || ping_timeout;
  assign gap_end      = (state_q == GAP) && (timer_q == CNT_W'(GAP_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable && |mask)             state_d = PICK;
      PICK: if (!enable || !next_found)      state_d = IDLE;
            else                             state_d = PING;
      PING: if (ping_exit)                   state_d = GAP;
      GAP:  if (gap_end)                     state_d = PICK;
      default:                               state_d = IDLE;
    endcase
  end

  always_comb begin
    req  = (state_q == PING);
    busy = (state_q != IDLE);
  end

  // One timer serves both the ping timeout and the quiet gap; it restarts on every state change.
  always_comb begin
    timer_d = '0;
    if ((state_q == PING && !ping_exit) || (state_q == GAP && !gap_end))
      timer_d = timer_q + 1'b1;

    ptr_d = ptr_q;
    sel_d = sel_q;
    if (state_q == PICK && enable && next_found) begin
      ptr_d = next_id;
      sel_d = next_id;
    end

    res_valid_d   = ping_exit;
    res_id_d      = res_id_q;
    res_cm_d      = res_cm_q;
    res_timeout_d = res_timeout_q;
    tbl_d         = tbl_q;
    if (ping_exit) begin
      res_id_d         = sel_q;
      res_cm_d         = ping_done ? cm : '1;
      res_timeout_d    = !ping_done;
      tbl_d[sel_q]     = ping_done ? cm : '1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      ptr_q         <= ID_W'(N_SENSORS - 1);
      sel_q         <= '0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_cm_q      <= '0;
      res_timeout_q <= 1'b0;
      for (int i = 0; i < N_SENSORS; i++) tbl_q[i] <= '1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_cm_q      <= res_cm_d;
      res_timeout_q <= res_timeout_d;
      tbl_q         <= tbl_d;
    end
  end

  assign sel         = sel_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_cm      = res_cm_q;
  assign res_timeout = res_timeout_q;
  assign rd_cm       = (int'(rd_id) < N_SENSORS) ? tbl_q[rd_id] : '1;

`ifdef PING_SCHED_NEAREST_EN
  logic [CM_W-1:0] near_cm_q, near_cm_d;
  logic [ID_W-1:0] near_id_q, near_id_d;

  // Strict less-than keeps the lowest id on ties; all-ones entries never win.
  always_comb begin
    near_cm_d = '1;
    near_id_d = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (mask[i] && (tbl_q[i] < near_cm_d)) begin
        near_cm_d = tbl_q[i];
        near_id_d = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      near_cm_q <= '1;
      near_id_q <= '0;
    end else begin
      near_cm_q <= near_cm_d;
      near_id_q <= near_id_d;
    end
  end

  assign near_cm = near_cm_q;
  assign near_id = near_id_q;
`else
  // Nearest-reading tracker not built in this configuration.
`endif

endmodule

// File: tb/tb_ping_scheduler.sv
// Self-checking bench for ping_scheduler: engine model drives done/cm and queues expected results.
module tb_ping_scheduler;

  typedef struct packed {
    logic [1:0] id;
    logic [8:0] cm;
    logic       to;
  } res_t;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [3:0] mask;
  logic       req;
  logic [1:0] sel;
  logic       done;
  logic [8:0] cm;
  logic       res_valid;
  logic [1:0] res_id;
  logic [8:0] res_cm;
  logic       res_timeout;
  logic [1:0] rd_id;
  logic [8:0] rd_cm;
  logic       busy;
`ifdef PING_SCHED_NEAREST_EN
  logic [8:0] near_cm;
  logic [1:0] near_id;
`endif

  int         vectors;
  int         miscompares;
  int         results_seen;
  int         delay [4];
  logic [8:0] val [4];
  res_t       exp_q [$];
  logic [1:0] sel_log [$];
  int         req_cycles;
  int         low_len;
  int         last_req_len;
  logic       seen_ping;
  logic [1:0] model_ptr;
  logic [1:0] exp_sel;

  ping_scheduler #(
    .N_SENSORS(4), .ID_W(2), .CM_W(9), .GAP_CYCLES(10), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mask(mask),
    .req(req), .sel(sel), .done(done), .cm(cm),
    .res_valid(res_valid), .res_id(res_id), .res_cm(res_cm), .res_timeout(res_timeout),
    .rd_id(rd_id), .rd_cm(rd_cm), .busy(busy)
`ifdef PING_SCHED_NEAREST_EN
    , .near_cm(near_cm), .near_id(near_id)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] m);
    @(negedge clk);
    enable = en;
    mask   = m;
  endtask

  function automatic logic [1:0] next_after(input logic [1:0] p, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] c;
    r = p;
    for (int i = 4; i >= 1; i--) begin
      c = p + 2'(i);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  // Engine model: tracks the expected rotation, answers after delay[id] req cycles, queues results.
  initial begin
    done = 1'b0; cm = '0; model_ptr = 2'd3; exp_sel = '0;
    req_cycles = 0; low_len = 0; last_req_len = 0; seen_ping = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        model_ptr = 2'd3; req_cycles = 0; low_len = 0; seen_ping = 1'b0; done = 1'b0;
      end else if (req) begin
        if (req_cycles == 0) begin
          exp_sel   = next_after(model_ptr, mask);
          model_ptr = exp_sel;
          checkOutput("sel_rotation", 32'(sel), 32'(exp_sel));
          if (seen_ping) checkOutput("gap_at_least_10", 32'(low_len >= 10), 32'd1);
          sel_log.push_back(sel);
          if (delay[exp_sel] == 0 || delay[exp_sel] > 50)
            exp_q.push_back(res_t'{id: exp_sel, cm: 9'h1FF, to: 1'b1});
        end
        req_cycles++;
        low_len = 0;
        if (delay[exp_sel] == req_cycles) begin
          done = 1'b1;
          cm   = val[exp_sel];
          exp_q.push_back(res_t'{id: exp_sel, cm: val[exp_sel], to: 1'b0});
        end else begin
          done = 1'b0;
          cm   = 9'($urandom);
        end
      end else begin
        if (req_cycles > 0) begin
          last_req_len = req_cycles;
          checkOutput("sel_hold_after_req", 32'(sel), 32'(exp_sel));
          seen_ping = 1'b1;
        end
        req_cycles = 0;
        done       = 1'b0;
        low_len++;
      end
    end
  end

  // Result checker: every res_valid pulse pops one expectation.
  initial begin
    res_t e;
    results_seen = 0;
    forever begin
      @(negedge clk);
      if (resetn && res_valid) begin
        results_seen++;
        checkOutput("result_was_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("res_id", 32'(res_id), 32'(e.id));
          checkOutput("res_cm", 32'(res_cm), 32'(e.cm));
          checkOutput("res_timeout", 32'(res_timeout), 32'(e.to));
        end
      end
    end
  end

  task automatic wait_results(input int n, input int budget);
    int target;
    target = results_seen + n;
    for (int i = 0; i < budget && results_seen < target; i++) @(negedge clk);
    checkOutput("results_within_budget", 32'(results_seen >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
    checkOutput("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    sel_log.delete();
    resetn = 1'b1;
  endtask

  task automatic check_rd(input logic [1:0] id, input logic [8:0] exp);
    rd_id = id;
    #1;
    checkOutput($sformatf("rd_cm[%0d]", id), 32'(rd_cm), 32'(exp));
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst_req", 32'(req), 32'd0);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_id", 32'(res_id), 32'd0);
    checkOutput("rst_res_cm", 32'(res_cm), 32'd0);
    checkOutput("rst_res_timeout", 32'(res_timeout), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int req_highs;
    vectors = 0; miscompares = 0;
    resetn = 1'b0; enable = 1'b0; mask = '0; rd_id = '0;
    for (int i = 0; i < 4; i++) begin
      delay[i] = 5;
      val[i]   = 9'(100 + i);
    end

    // Reset values, including an all-ones table.
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    for (int i = 0; i < 4; i++) check_rd(2'(i), 9'h1FF);
    @(negedge clk);
    resetn = 1'b1;

    // Test 1: full rotation.
    applyStimulus(1'b1, 4'b1111);
    wait_results(5, 200);
    applyStimulus(1'b0, 4'b1111);
    wait_idle(100);
    checkOutput("t1_pings", 32'(sel_log.size()), 32'd5);
    if (sel_log.size() >= 5) begin
      checkOutput("t1_sel0", 32'(sel_log[0]), 32'd0);
      checkOutput("t1_sel1", 32'(sel_log[1]), 32'd1);
      checkOutput("t1_sel2", 32'(sel_log[2]), 32'd2);
      checkOutput("t1_sel3", 32'(sel_log[3]), 32'd3);
      checkOutput("t1_sel4", 32'(sel_log[4]), 32'd0);
    end
    for (int i = 0; i < 4; i++) check_rd(2'(i), 9'(100 + i));

    // Test 2: sparse mask, untouched sensors keep no-reading.
    do_reset();
    applyStimulus(1'b1, 4'b0101);
    wait_results(4, 200);
    applyStimulus(1'b0, 4'b0101);
    wait_idle(100);
    checkOutput("t2_pings", 32'(sel_log.size()), 32'd4);
    if (sel_log.size() >= 4) begin
      checkOutput("t2_sel0", 32'(sel_log[0]), 32'd0);
      checkOutput("t2_sel1", 32'(sel_log[1]), 32'd2);
      checkOutput("t2_sel2", 32'(sel_log[2]), 32'd0);
      checkOutput("t2_sel3", 32'(sel_log[3]), 32'd2);
    end
    check_rd(2'd1, 9'h1FF);
    check_rd(2'd3, 9'h1FF);
    check_rd(2'd0, 9'd100);
    check_rd(2'd2, 9'd102);

    // Test 3: dead sensor times out after exactly 50 req cycles, gap still enforced.
    delay[1] = 0;
    applyStimulus(1'b1, 4'b0010);
    wait_results(1, 200);
    @(negedge clk);
    checkOutput("t3_req_len", 32'(last_req_len), 32'd50);
    checkOutput("t3_timeout_held", 32'(res_timeout), 32'd1);
    wait_results(1, 200);
    applyStimulus(1'b0, 4'b0010);
    wait_idle(100);
    check_rd(2'd1, 9'h1FF);

    // Test 4: done lands on the final timeout cycle.
    delay[1] = 50;
    val[1]   = 9'd77;
    applyStimulus(1'b1, 4'b0010);
    wait_results(1, 200);
    @(negedge clk);
    checkOutput("t4_req_len", 32'(last_req_len), 32'd50);
    checkOutput("t4_timeout_flag", 32'(res_timeout), 32'd0);
    applyStimulus(1'b0, 4'b0010);
    wait_idle(100);
    check_rd(2'd1, 9'd77);

    // Test 5: enable drops mid-ping of sensor 2.
    for (int i = 0; i < 4; i++) begin
      delay[i] = 20;
      val[i]   = 9'(100 + i);
    end
    applyStimulus(1'b1, 4'b1111);
    for (int i = 0; i < 100 && !(req === 1'b1 && sel === 2'd2); i++) @(negedge clk);
    checkOutput("t5_ping2_started", 32'(req === 1'b1 && sel === 2'd2), 32'd1);
    enable = 1'b0;
    wait_results(1, 100);
    wait_idle(100);
    checkOutput("t5_res_id", 32'(res_id), 32'd2);
    checkOutput("t5_res_cm", 32'(res_cm), 32'd102);
    req_highs = 0;
    repeat (30) begin
      @(negedge clk);
      if (req !== 1'b0) req_highs++;
    end
    checkOutput("t5_req_stays_low", 32'(req_highs), 32'd0);
    checkOutput("t5_queue_drained", 32'(exp_q.size()), 32'd0);

    // Test 6: nearest reading, then reset in the middle of a ping.
    do_reset();
    val[0] = 9'd200; val[1] = 9'd45; val[2] = 9'd45; val[3] = 9'd300;
    for (int i = 0; i < 4; i++) delay[i] = 5;
    applyStimulus(1'b1, 4'b1111);
    wait_results(4, 200);
    applyStimulus(1'b0, 4'b1111);
    repeat (3) @(negedge clk);
`ifdef PING_SCHED_NEAREST_EN
    checkOutput("t6_near_cm", 32'(near_cm), 32'd45);
    checkOutput("t6_near_id", 32'(near_id), 32'd1);
`endif
    check_rd(2'd3, 9'd300);
    wait_idle(100);
    delay[0] = 30; delay[1] = 30; delay[2] = 30; delay[3] = 30;
    applyStimulus(1'b1, 4'b1111);
    for (int i = 0; i < 50 && req !== 1'b1; i++) @(negedge clk);
    checkOutput("t6_req_before_reset", 32'(req), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    check_rd(2'd1, 9'h1FF);
`ifdef PING_SCHED_NEAREST_EN
    checkOutput("t6_rst_near_cm", 32'(near_cm), 32'h1FF);
    checkOutput("t6_rst_near_id", 32'(near_id), 32'd0);
`endif
    enable = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_idle_after_reset", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
